// File: rtl/bounce_motion_engine.sv
// ---------------------------------------------------------------------------
// bounce_motion_engine
//
// Frame-synchronous motion controller for one circular sprite. On every
// TICK_DIV-th frame tick (while enabled) it runs a short step sequence:
// it computes the next x position, then the next y position, and then shows
// both axes, both directions and the bounce flags together in one cycle.
// Each axis either reflects off its bounds or wraps around to the opposite
// side.
//
// Ports
//   i_clk            pixel clock
//   i_reset          synchronous active-high reset
//   i_frame_tick     one-cycle pulse per frame
//   i_enable         1 = run, 0 = pause (divider and motion frozen)
//   i_mode           0 = bounce at bounds, 1 = wrap at bounds
//   i_speed_x/y      step magnitude per axis (pixels per step)
//   i_kick_x/y       pulse: invert that axis direction at the next step
//   i_load           pulse: load i_load_x/i_load_y (clamped), abort step
//   i_load_x/y       load coordinates
//   o_pos_x/y        sprite centre
//   o_dir_x/y        1 = increasing coordinate, 0 = decreasing
//   o_busy           a step sequence is in progress
//   o_update_done    one-cycle pulse when a new position is shown
//   o_bounce_x/y     one-cycle pulse alongside o_update_done on reflection
//   o_bounce_count   total reflections, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module bounce_motion_engine #(
    parameter int COORD_W  = 10,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int RADIUS   = 100,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int SPEED_W  = 3,
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_frame_tick,
    input  logic               i_enable,
    input  logic               i_mode,
    input  logic [SPEED_W-1:0] i_speed_x,
    input  logic [SPEED_W-1:0] i_speed_y,
    input  logic               i_kick_x,
    input  logic               i_kick_y,
    input  logic               i_load,
    input  logic [COORD_W-1:0] i_load_x,
    input  logic [COORD_W-1:0] i_load_y,
    output logic [COORD_W-1:0] o_pos_x,
    output logic [COORD_W-1:0] o_pos_y,
    output logic               o_dir_x,
    output logic               o_dir_y,
    output logic               o_busy,
    output logic               o_update_done,
    output logic               o_bounce_x,
    output logic               o_bounce_y,
    output logic [CNT_W-1:0]   o_bounce_count
);

    localparam int X_MIN = RADIUS;
    localparam int X_MAX = H_RES - 1 - RADIUS;
    localparam int Y_MIN = RADIUS;
    localparam int Y_MAX = V_RES - 1 - RADIUS;

    // Two extra bits give headroom above the largest coordinate and a sign
    // bit, so overshoot past either bound is seen before wrapping or clamping.
    localparam int SW = COORD_W + 2;
    typedef logic signed [SW-1:0] sword_t;

    localparam sword_t X_MIN_S = sword_t'(X_MIN);
    localparam sword_t X_MAX_S = sword_t'(X_MAX);
    localparam sword_t Y_MIN_S = sword_t'(Y_MIN);
    localparam sword_t Y_MAX_S = sword_t'(Y_MAX);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC_X,
        S_CALC_Y,
        S_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [DIV_W-1:0]   r_div;
    logic [COORD_W-1:0] r_posX;
    logic [COORD_W-1:0] r_posY;
    logic               r_dirX;
    logic               r_dirY;
    logic               r_kickX;
    logic               r_kickY;
    logic [COORD_W-1:0] r_shadowX;
    logic               r_shadowDirX;
    logic               r_bounceX;
    logic               r_bounceY;
    logic [CNT_W-1:0]   r_bounceCount;

    logic               w_stepGo;
    logic               w_isX;
    sword_t             w_cur;
    sword_t             w_spd;
    sword_t             w_min;
    sword_t             w_max;
    sword_t             w_sum;
    sword_t             w_res;
    logic               w_dirWork;
    logic               w_resDir;
    logic               w_resBounce;
    logic [COORD_W-1:0] w_resPos;
    logic [1:0]         w_unusedBits;

    // Load coordinates are forced into the legal centre range.
    function automatic logic [COORD_W-1:0] clampCoord(input logic [COORD_W-1:0] v,
                                                     input int lo, input int hi);
        logic [COORD_W-1:0] r;
        r = v;
        if (v < COORD_W'(lo)) r = COORD_W'(lo);
        else if (v > COORD_W'(hi)) r = COORD_W'(hi);
        return r;
    endfunction

    // A step starts only from IDLE, when enabled, on the tick that completes
    // the divider period; a simultaneous load suppresses it.
    assign w_stepGo = (r_state == S_IDLE) && i_frame_tick && i_enable &&
                      (r_div == DIV_LAST) && !i_load;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    // Next-state logic; load aborts any sequence back to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_stepGo) w_nextState = S_CALC_X;
            S_CALC_X: w_nextState = S_CALC_Y;
            S_CALC_Y: w_nextState = S_COMMIT;
            S_COMMIT: w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
        if (i_load) w_nextState = S_IDLE;
    end

    // One shared axis step unit: x operands in CALC_X, y operands otherwise.
    // The pending kick flips the working direction before the move.
    always_comb begin
        w_isX       = (r_state == S_CALC_X);
        w_cur       = w_isX ? $signed({2'b00, r_posX}) : $signed({2'b00, r_posY});
        w_spd       = w_isX ? $signed({{(SW-SPEED_W){1'b0}}, i_speed_x})
                            : $signed({{(SW-SPEED_W){1'b0}}, i_speed_y});
        w_min       = w_isX ? X_MIN_S : Y_MIN_S;
        w_max       = w_isX ? X_MAX_S : Y_MAX_S;
        w_dirWork   = w_isX ? (r_dirX ^ r_kickX) : (r_dirY ^ r_kickY);
        w_sum       = w_dirWork ? (w_cur + w_spd) : (w_cur - w_spd);
        w_res       = w_sum;
        w_resDir    = w_dirWork;
        w_resBounce = 1'b0;
        if (w_sum > w_max) begin
            if (i_mode) begin
                w_res = w_sum - (w_max - w_min + sword_t'(1));
            end else begin
                w_res       = w_max;
                w_resDir    = 1'b0;
                w_resBounce = 1'b1;
            end
        end else if (w_sum < w_min) begin
            if (i_mode) begin
                w_res = w_sum + (w_max - w_min + sword_t'(1));
            end else begin
                w_res       = w_min;
                w_resDir    = 1'b1;
                w_resBounce = 1'b1;
            end
        end
        w_resPos     = w_res[COORD_W-1:0];
        w_unusedBits = w_res[SW-1:COORD_W];
    end

    // Datapath. The x result waits in a shadow register; at the end of
    // CALC_Y both axes, both directions and the counter are written together,
    // so in the COMMIT cycle every output already shows the new frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div         <= '0;
            r_posX        <= COORD_W'(X_INIT);
            r_posY        <= COORD_W'(Y_INIT);
            r_dirX        <= 1'b1;
            r_dirY        <= 1'b1;
            r_kickX       <= 1'b0;
            r_kickY       <= 1'b0;
            r_shadowX     <= '0;
            r_shadowDirX  <= 1'b0;
            r_bounceX     <= 1'b0;
            r_bounceY     <= 1'b0;
            r_bounceCount <= '0;
        end else if (i_load) begin
            r_posX    <= clampCoord(i_load_x, X_MIN, X_MAX);
            r_posY    <= clampCoord(i_load_y, Y_MIN, Y_MAX);
            r_kickX   <= 1'b0;
            r_kickY   <= 1'b0;
            r_bounceX <= 1'b0;
            r_bounceY <= 1'b0;
        end else begin
            if (i_kick_x)                   r_kickX <= 1'b1;
            else if (r_state == S_COMMIT)   r_kickX <= 1'b0;
            if (i_kick_y)                   r_kickY <= 1'b1;
            else if (r_state == S_COMMIT)   r_kickY <= 1'b0;

            if ((r_state == S_IDLE) && i_frame_tick && i_enable) begin
                if (r_div == DIV_LAST) r_div <= '0;
                else                   r_div <= r_div + DIV_W'(1);
            end

            case (r_state)
                S_CALC_X: begin
                    r_shadowX    <= w_resPos;
                    r_shadowDirX <= w_resDir;
                    r_bounceX    <= w_resBounce;
                end
                S_CALC_Y: begin
                    r_posX        <= r_shadowX;
                    r_dirX        <= r_shadowDirX;
                    r_posY        <= w_resPos;
                    r_dirY        <= w_resDir;
                    r_bounceY     <= w_resBounce;
                    r_bounceCount <= r_bounceCount + CNT_W'(r_bounceX) + CNT_W'(w_resBounce);
                end
                default: ;
            endcase
        end
    end

    assign o_pos_x        = r_posX;
    assign o_pos_y        = r_posY;
    assign o_dir_x        = r_dirX;
    assign o_dir_y        = r_dirY;
    assign o_busy         = (r_state != S_IDLE);
    assign o_update_done  = (r_state == S_COMMIT);
    assign o_bounce_x     = (r_state == S_COMMIT) && r_bounceX;
    assign o_bounce_y     = (r_state == S_COMMIT) && r_bounceY;
    assign o_bounce_count = r_bounceCount;

endmodule

// File: tb/tb_bounce_motion_engine.sv
// ---------------------------------------------------------------------------
// tb_bounce_motion_engine
//
// Bench for bounce_motion_engine. Two instances share all inputs: dut1 uses
// TICK_DIV=1 for motion checks, dut3 uses TICK_DIV=3 for the frame divider.
// ---------------------------------------------------------------------------
module tb_bounce_motion_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       frameTick;
    logic       enable;
    logic       mode;
    logic [2:0] speedX;
    logic [2:0] speedY;
    logic       kickX;
    logic       kickY;
    logic       load;
    logic [9:0] loadX;
    logic [9:0] loadY;

    logic [9:0] o1PosX, o1PosY, o3PosX, o3PosY;
    logic       o1DirX, o1DirY, o1Busy, o1Done, o1Bx, o1By;
    logic       o3DirX, o3DirY, o3Busy, o3Done, o3Bx, o3By;
    logic [7:0] o1Cnt, o3Cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state for the randomized phase.
    int   mx, my, mcnt;
    logic mdx, mdy, mkx, mky;

    typedef struct {
        logic doLoad;
        int   lx;
        int   ly;
        logic md;
        int   sx;
        int   sy;
        logic kx;
        logic ky;
        int   ex;
        int   ey;
        logic edx;
        logic edy;
        logic ebx;
        logic eby;
        int   ecnt;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    // Motion instance with one step per frame tick.
    bounce_motion_engine #(.TICK_DIV(1)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_frame_tick(frameTick), .i_enable(enable),
        .i_mode(mode), .i_speed_x(speedX), .i_speed_y(speedY),
        .i_kick_x(kickX), .i_kick_y(kickY), .i_load(load),
        .i_load_x(loadX), .i_load_y(loadY),
        .o_pos_x(o1PosX), .o_pos_y(o1PosY), .o_dir_x(o1DirX), .o_dir_y(o1DirY),
        .o_busy(o1Busy), .o_update_done(o1Done), .o_bounce_x(o1Bx), .o_bounce_y(o1By),
        .o_bounce_count(o1Cnt)
    );

    // Divider instance stepping on every third enabled frame tick.
    bounce_motion_engine #(.TICK_DIV(3)) dut3 (
        .i_clk(clk), .i_reset(reset), .i_frame_tick(frameTick), .i_enable(enable),
        .i_mode(mode), .i_speed_x(speedX), .i_speed_y(speedY),
        .i_kick_x(kickX), .i_kick_y(kickY), .i_load(load),
        .i_load_x(loadX), .i_load_y(loadY),
        .o_pos_x(o3PosX), .o_pos_y(o3PosY), .o_dir_x(o3DirX), .o_dir_y(o3DirY),
        .o_busy(o3Busy), .o_update_done(o3Done), .o_bounce_x(o3Bx), .o_bounce_y(o3By),
        .o_bounce_count(o3Cnt)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic doLoad(input int lx, input int ly);
        loadX = 10'(lx);
        loadY = 10'(ly);
        load  = 1'b1;
        cyc();
        load  = 1'b0;
    endtask

    task automatic doKick(input logic kx, input logic ky);
        if (kx || ky) begin
            kickX = kx;
            kickY = ky;
            cyc();
            kickX = 1'b0;
            kickY = 1'b0;
        end
    endtask

    // Tick, then check busy across the step; returns positioned at T+3.
    task automatic runStep();
        frameTick = 1'b1;
        cyc();
        frameTick = 1'b0;
        checkOutput("busyT1", int'(o1Busy), 1);
        cyc();
        checkOutput("busyT2", int'(o1Busy), 1);
        cyc();
        checkOutput("busyT3", int'(o1Busy), 1);
    endtask

    // One cycle after COMMIT every pulse must be gone and the engine idle.
    task automatic endStep();
        cyc();
        checkOutput("doneAfter", int'(o1Done), 0);
        checkOutput("bxAfter", int'(o1Bx), 0);
        checkOutput("busyAfter", int'(o1Busy), 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        mode   = v.md;
        speedX = 3'(v.sx);
        speedY = 3'(v.sy);
        if (v.doLoad) doLoad(v.lx, v.ly);
        doKick(v.kx, v.ky);
        runStep();
    endtask

    // Count update_done pulses of both instances over the five cycles
    // following a frame tick.
    task automatic tickWatch(output int n1, output int n3);
        n1 = 0;
        n3 = 0;
        frameTick = 1'b1;
        cyc();
        frameTick = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n1 += int'(o1Done);
            n3 += int'(o3Done);
            cyc();
        end
    endtask

    // Reference rule for one axis: move by speed in the (possibly kicked)
    // direction, then reflect or wrap if the bounds are crossed.
    task automatic modelAxis(inout int p, inout logic d, input int s, input logic pend,
                             input logic wrap, input int lo, input int hi, output logic b);
        int n;
        d = d ^ pend;
        n = d ? p + s : p - s;
        b = 1'b0;
        if (n > hi) begin
            if (wrap) n = n - (hi - lo + 1);
            else begin n = hi; d = 1'b0; b = 1'b1; end
        end else if (n < lo) begin
            if (wrap) n = n + (hi - lo + 1);
            else begin n = lo; d = 1'b1; b = 1'b1; end
        end
        p = n;
    endtask

    function automatic int clampI(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Stimulus vectors with hand-derived expectations (bounds x 100..539,
    // y 100..379); direction and counter carry from one vector to the next.
    initial begin
        vecs[0]  = '{1'b0,   0,    0, 1'b0, 1, 1, 1'b0, 1'b0, 321, 241, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 537,  240, 1'b0, 4, 0, 1'b0, 1'b0, 539, 240, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[2]  = '{1'b0,   0,    0, 1'b0, 4, 0, 1'b0, 1'b0, 535, 240, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{1'b1, 537,  378, 1'b1, 4, 4, 1'b1, 1'b0, 101, 102, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[4]  = '{1'b1, 101,  240, 1'b1, 4, 0, 1'b1, 1'b0, 537, 240, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[5]  = '{1'b1, 320,  240, 1'b0, 0, 0, 1'b1, 1'b0, 320, 240, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{1'b0,   0,    0, 1'b0, 2, 0, 1'b1, 1'b0, 318, 240, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[7]  = '{1'b1, 538,  378, 1'b0, 3, 3, 1'b1, 1'b0, 539, 379, 1'b0, 1'b0, 1'b1, 1'b1, 3};
        vecs[8]  = '{1'b0,   0,    0, 1'b0, 7, 7, 1'b0, 1'b0, 532, 372, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[9]  = '{1'b1, 102,  101, 1'b0, 7, 7, 1'b0, 1'b0, 100, 100, 1'b1, 1'b1, 1'b1, 1'b1, 5};
        vecs[10] = '{1'b1,   5, 1000, 1'b0, 0, 0, 1'b0, 1'b0, 100, 379, 1'b1, 1'b1, 1'b0, 1'b0, 5};
        vecs[11] = '{1'b1, 535,  375, 1'b0, 4, 4, 1'b0, 1'b0, 539, 379, 1'b1, 1'b1, 1'b0, 1'b0, 5};
    end

    initial begin
        int   n1;
        int   n3;
        int   lx;
        int   ly;
        logic bxm;
        logic bym;

        reset = 1'b1; frameTick = 1'b0; enable = 1'b1; mode = 1'b0;
        speedX = '0; speedY = '0; kickX = 1'b0; kickY = 1'b0;
        load = 1'b0; loadX = '0; loadY = '0;

        // Reset values.
        doReset();
        checkOutput("rstPosX", int'(o1PosX), 320);
        checkOutput("rstPosY", int'(o1PosY), 240);
        checkOutput("rstDirX", int'(o1DirX), 1);
        checkOutput("rstDirY", int'(o1DirY), 1);
        checkOutput("rstBusy", int'(o1Busy), 0);
        checkOutput("rstDone", int'(o1Done), 0);
        checkOutput("rstCnt", int'(o1Cnt), 0);

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_done", i), int'(o1Done), 1);
            checkOutput($sformatf("v%0d_x", i), int'(o1PosX), vecs[i].ex);
            checkOutput($sformatf("v%0d_y", i), int'(o1PosY), vecs[i].ey);
            checkOutput($sformatf("v%0d_dx", i), int'(o1DirX), int'(vecs[i].edx));
            checkOutput($sformatf("v%0d_dy", i), int'(o1DirY), int'(vecs[i].edy));
            checkOutput($sformatf("v%0d_bx", i), int'(o1Bx), int'(vecs[i].ebx));
            checkOutput($sformatf("v%0d_by", i), int'(o1By), int'(vecs[i].eby));
            checkOutput($sformatf("v%0d_cnt", i), int'(o1Cnt), vecs[i].ecnt);
            endStep();
        end

        // Randomized phase against the reference model, starting from the
        // state the last directed vector leaves behind.
        mx = 539; my = 379; mdx = 1'b1; mdy = 1'b1; mcnt = 5; mkx = 1'b0; mky = 1'b0;
        for (int i = 0; i < 150; i++) begin
            mode   = 1'($urandom_range(0, 1));
            speedX = 3'($urandom_range(0, 7));
            speedY = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                lx = int'($urandom_range(0, 1023));
                ly = int'($urandom_range(0, 1023));
                doLoad(lx, ly);
                mx = clampI(lx, 100, 539);
                my = clampI(ly, 100, 379);
                mkx = 1'b0;
                mky = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin doKick(1'b1, 1'b0); mkx = 1'b1; end
            if ($urandom_range(0, 3) == 0) begin doKick(1'b0, 1'b1); mky = 1'b1; end
            runStep();
            modelAxis(mx, mdx, int'(speedX), mkx, mode, 100, 539, bxm);
            modelAxis(my, mdy, int'(speedY), mky, mode, 100, 379, bym);
            mkx = 1'b0;
            mky = 1'b0;
            mcnt = (mcnt + int'(bxm) + int'(bym)) % 256;
            checkOutput("rndDone", int'(o1Done), 1);
            checkOutput("rndX", int'(o1PosX), mx);
            checkOutput("rndY", int'(o1PosY), my);
            checkOutput("rndDx", int'(o1DirX), int'(mdx));
            checkOutput("rndDy", int'(o1DirY), int'(mdy));
            checkOutput("rndBx", int'(o1Bx), int'(bxm));
            checkOutput("rndBy", int'(o1By), int'(bym));
            checkOutput("rndCnt", int'(o1Cnt), mcnt);
            endStep();
        end

        // Reset in the middle of a step.
        mode = 1'b0; speedX = 3'd1; speedY = 3'd1;
        doLoad(200, 200);
        frameTick = 1'b1;
        cyc();
        frameTick = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checkOutput("midRstX", int'(o1PosX), 320);
        checkOutput("midRstY", int'(o1PosY), 240);
        checkOutput("midRstBusy", int'(o1Busy), 0);
        checkOutput("midRstCnt", int'(o1Cnt), 0);
        n1 = 0;
        for (int k = 0; k < 5; k++) begin n1 += int'(o1Done); cyc(); end
        checkOutput("midRstNoDone", n1, 0);

        // Load arriving two cycles after the tick aborts the step.
        frameTick = 1'b1;
        cyc();
        frameTick = 1'b0;
        cyc();
        doLoad(250, 150);
        checkOutput("midLdBusy", int'(o1Busy), 0);
        checkOutput("midLdDone", int'(o1Done), 0);
        checkOutput("midLdX", int'(o1PosX), 250);
        checkOutput("midLdY", int'(o1PosY), 150);
        n1 = 0;
        for (int k = 0; k < 5; k++) begin n1 += int'(o1Done); cyc(); end
        checkOutput("midLdNoDone", n1, 0);

        // Load and tick in the same cycle: the tick is dropped.
        loadX = 10'd300; loadY = 10'd300; load = 1'b1; frameTick = 1'b1;
        cyc();
        load = 1'b0; frameTick = 1'b0;
        n1 = 0;
        for (int k = 0; k < 5; k++) begin n1 += int'(o1Done); cyc(); end
        checkOutput("ldTickNoDone", n1, 0);
        checkOutput("ldTickX", int'(o1PosX), 300);
        checkOutput("ldTickY", int'(o1PosY), 300);

        // Frame divider of three, with a paused stretch and a tick while busy.
        doReset();
        enable = 1'b1;
        tickWatch(n1, n3); checkOutput("div1", n3, 0);
        tickWatch(n1, n3); checkOutput("div2", n3, 0);
        tickWatch(n1, n3); checkOutput("div3", n3, 1);
        tickWatch(n1, n3); checkOutput("div4", n3, 0);
        enable = 1'b0;
        tickWatch(n1, n3); checkOutput("pause1d3", n3, 0); checkOutput("pause1d1", n1, 0);
        tickWatch(n1, n3); checkOutput("pause2d3", n3, 0); checkOutput("pause2d1", n1, 0);
        enable = 1'b1;
        tickWatch(n1, n3); checkOutput("div5", n3, 0);
        frameTick = 1'b1;
        cyc();
        frameTick = 1'b0;
        checkOutput("div6Busy", int'(o3Busy), 1);
        tickWatch(n1, n3); checkOutput("div6", n3, 1);
        tickWatch(n1, n3); checkOutput("div7", n3, 0);
        tickWatch(n1, n3); checkOutput("div8", n3, 0);
        tickWatch(n1, n3); checkOutput("div9", n3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
